instr_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 16-bit core. Fetches instructions over a
//  req/ack memory port and holds the word in ir, which drives the instruction

---
 rtl/instr_sequencer.sv | 136 +++++++++++++
 tb/tb_instr_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 16-bit core: fetch, decode gating,
// ALU start/done handshake with timeout, and one-cycle write-back strobes.
module instr_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     ir,
  input  logic [3:0]      opcode,
  input  logic            cond_code_success,
  output logic            alu_start,
  input  logic            alu_done,
  output logic            rf_we,
  output logic            flag_we,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     retired,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [3:0]  OP_HALT = 4'b1111;
  localparam logic [3:0]  OP_JUMP = 4'b1100;
  localparam logic [3:0]  OP_CMP  = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc_nxt;
  logic [15:0]         ir_nxt;
  logic [15:0]         retired_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                is_cmp, is_cmp_nxt;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      retired  <= '0;
      wait_cnt <= '0;
      is_cmp   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      retired  <= retired_nxt;
      wait_cnt <= wait_nxt;
      is_cmp   <= is_cmp_nxt;
    end
  end

  // Next-state logic; alu_start depends only on decoder outputs driven from ir
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    retired_nxt = retired;
    wait_nxt    = wait_cnt;
    is_cmp_nxt  = is_cmp;
    alu_start   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          pc_nxt    = pc + PC_W'(1);
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_code_success) begin
          retired_nxt = retired + 16'd1;
          state_nxt   = S_FETCH;
        end else if (opcode == OP_HALT) begin
          retired_nxt = retired + 16'd1;
          state_nxt   = S_HALT;
        end else if (opcode == OP_JUMP) begin
          pc_nxt      = PC_W'(ir[6:0]);
          retired_nxt = retired + 16'd1;
          state_nxt   = S_FETCH;
        end else begin
          alu_start  = 1'b1;
          wait_nxt   = '0;
          is_cmp_nxt = (opcode == OP_CMP);
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_done) begin
          state_nxt = S_WB;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(ALU_TIMEOUT - 1)) state_nxt = S_ERROR;
        end
      end
      S_WB: begin
        retired_nxt = retired + 16'd1;
        state_nxt   = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign flag_we   = (state == S_WB);
  assign rf_we     = (state == S_WB) && !is_cmp;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WB);
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERROR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: cycle model of the sequencing rules,
// checked every cycle, plus hand-computed literal expectations.
module tb_instr_sequencer;

  localparam int unsigned PC_W = 8;
  localparam int unsigned TMO  = 4;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3,
                 P_WB = 4, P_HALT = 5, P_ERR = 6;

  logic            clk = 1'b0;
  logic            rst, start, imem_ack, alu_done;
  logic [15:0]     imem_rdata;
  logic [3:0]      opcode;
  logic            cond_code_success;
  logic            imem_req, alu_start, rf_we, flag_we, busy, halted, err;
  logic [PC_W-1:0] imem_addr, pc;
  logic [15:0]     ir, retired;

  logic [3:0]      cc_ok;
  logic [15:0]     mem [0:255];
  int              ack_lat, alu_lat;
  bit              done_in_decode, force_ack;
  int              n_chk, n_fail;

  // Reference model state
  int              m_ph, m_w, m_req;
  logic [7:0]      m_pc;
  logic [15:0]     m_ir, m_ret;

  always #5 clk = ~clk;

  // Stand-in for the instruction decoder
  assign opcode            = ir[13:10];
  assign cond_code_success = cc_ok[ir[15:14]];

  instr_sequencer #(.PC_W(PC_W), .ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode),
    .cond_code_success(cond_code_success), .alu_start(alu_start),
    .alu_done(alu_done), .rf_we(rf_we), .flag_we(flag_we), .pc(pc),
    .retired(retired), .busy(busy), .halted(halted), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_launches();
    return cc_ok[m_ir[15:14]] && (m_ir[13:10] != 4'hF) && (m_ir[13:10] != 4'hC);
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance model
  task automatic cycle(input bit r, input bit s);
    bit ack, done;
    @(negedge clk);
    chk("imem_req",  32'(imem_req),  32'(m_ph == P_FETCH));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("pc",        32'(pc),        32'(m_pc));
    chk("ir",        32'(ir),        32'(m_ir));
    chk("retired",   32'(retired),   32'(m_ret));
    chk("alu_start", 32'(alu_start), 32'(m_ph == P_DEC && m_launches()));
    chk("flag_we",   32'(flag_we),   32'(m_ph == P_WB));
    chk("rf_we",     32'(rf_we),     32'(m_ph == P_WB && m_ir[13:10] != 4'hE));
    chk("busy",      32'(busy),      32'(m_ph >= P_FETCH && m_ph <= P_WB));
    chk("halted",    32'(halted),    32'(m_ph == P_HALT));
    chk("err",       32'(err),       32'(m_ph == P_ERR));

    ack  = (m_ph == P_FETCH && m_req >= ack_lat) || force_ack;
    done = (m_ph == P_EXEC && alu_lat != 0 && m_w + 1 == alu_lat) ||
           (m_ph == P_DEC && done_in_decode);
    rst        = r;
    start      = s;
    imem_ack   = ack;
    imem_rdata = mem[m_pc];
    alu_done   = done;

    if (r) begin
      m_ph = P_IDLE; m_pc = '0; m_ir = '0; m_ret = '0; m_w = 0; m_req = 0;
    end else begin
      case (m_ph)
        P_IDLE: if (s) m_ph = P_FETCH;
        P_FETCH: begin
          if (ack) begin
            m_ir = mem[m_pc]; m_pc = m_pc + 8'd1; m_ph = P_DEC; m_req = 0;
          end else m_req++;
        end
        P_DEC: begin
          if (!cc_ok[m_ir[15:14]]) begin m_ret++; m_ph = P_FETCH; end
          else if (m_ir[13:10] == 4'hF) begin m_ret++; m_ph = P_HALT; end
          else if (m_ir[13:10] == 4'hC) begin
            m_pc = {1'b0, m_ir[6:0]}; m_ret++; m_ph = P_FETCH;
          end else begin m_w = 0; m_ph = P_EXEC; end
        end
        P_EXEC: begin
          if (done) m_ph = P_WB;
          else begin m_w++; if (m_w == TMO) m_ph = P_ERR; end
        end
        P_WB: begin m_ret++; m_ph = P_FETCH; end
        default: ;
      endcase
    end
  endtask

  initial begin
    int k;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; alu_done = 1'b0;
    cc_ok = 4'b1111; ack_lat = 0; alu_lat = 1; done_in_decode = 0; force_ack = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h3C00;
    m_ph = P_IDLE; m_pc = '0; m_ir = '0; m_ret = '0; m_w = 0; m_req = 0;
    repeat (2) @(negedge clk);

    // 1: single ALU op, 1-cycle fetch, done one cycle after start
    mem[0] = 16'h0412; mem[1] = 16'h3C00;
    cycle(1, 0);
    chk("t1_reset_busy", 32'(busy), 32'd0);
    cycle(0, 1);
    cycle(0, 0);                                  // FETCH
    cycle(0, 0);                                  // DECODE
    chk("t1_alu_start", 32'(alu_start), 32'd1);
    cycle(0, 0);                                  // EXEC
    cycle(0, 0);                                  // WB, cycle 4
    chk("t1_rf_we", 32'(rf_we), 32'd1);
    chk("t1_flag_we", 32'(flag_we), 32'd1);
    chk("t1_pc", 32'(pc), 32'd1);
    cycle(0, 0);                                  // next FETCH
    chk("t1_retired", 32'(retired), 32'd1);
    cycle(0, 0);
    cycle(0, 0);                                  // HALT
    chk("t1_halted", 32'(halted), 32'd1);
    cycle(0, 1); cycle(0, 1); cycle(0, 1);
    chk("t6_halt_ignores_start", 32'(halted), 32'd1);
    chk("t6_halt_retired", 32'(retired), 32'd2);

    // 2: annulled instruction with a 3-cycle fetch
    mem[0] = 16'h4412; cc_ok = 4'b1101; ack_lat = 2;
    cycle(1, 0); cycle(0, 1);
    cycle(0, 0); cycle(0, 0); cycle(0, 0);        // FETCH stalls, ack on third
    cycle(0, 0);                                  // DECODE
    chk("t2_no_alu_start", 32'(alu_start), 32'd0);
    cycle(0, 0);                                  // back in FETCH
    chk("t2_fetch", 32'(imem_req), 32'd1);
    chk("t2_pc", 32'(pc), 32'd1);
    chk("t2_retired", 32'(retired), 32'd1);
    for (int i = 0; i < 8; i++) cycle(0, 0);

    // 3: compare opcode writes flags only; stray done in DECODE ignored
    mem[0] = 16'h3805; cc_ok = 4'b1111; ack_lat = 0; alu_lat = 2; done_in_decode = 1;
    cycle(1, 0); cycle(0, 1);
    cycle(0, 0); cycle(0, 0); cycle(0, 0); cycle(0, 0);
    cycle(0, 0);                                  // WB
    chk("t3_flag_we", 32'(flag_we), 32'd1);
    chk("t3_rf_we", 32'(rf_we), 32'd0);
    for (int i = 0; i < 5; i++) cycle(0, 0);
    done_in_decode = 0;

    // 4: jumps, then annulled words up to 0xFF so pc wraps to 0
    mem[0] = 16'h3045; mem[8'h45] = 16'h307F;
    for (int i = 8'h7F; i < 256; i++) mem[i] = 16'h4412;
    cc_ok = 4'b1101; alu_lat = 1;
    cycle(1, 0); cycle(0, 1);
    cycle(0, 0); cycle(0, 0);
    cycle(0, 0);
    chk("t4_jump_addr", 32'(imem_addr), 32'h45);
    for (int i = 0; i < 400; i++) begin
      cycle(0, 0);
      if (imem_req && imem_addr == 8'h00) break;
    end
    chk("t4_wrap_req", 32'(imem_req), 32'd1);
    chk("t4_wrap_addr", 32'(imem_addr), 32'h00);
    chk("t4_wrap_retired", 32'(retired), 32'd131);

    // 5: ALU never answers; ERROR after ALU_TIMEOUT EXEC cycles of waiting
    mem[0] = 16'h0412; cc_ok = 4'b1111; alu_lat = 0;
    cycle(1, 0); cycle(0, 1);
    cycle(0, 0);
    cycle(0, 0);
    chk("t5_alu_start", 32'(alu_start), 32'd1);
    k = 0;
    do begin cycle(0, 0); k++; end while (!err && k < 20);
    chk("t5_err_latency", 32'(k), 32'(TMO + 1));
    chk("t5_busy", 32'(busy), 32'd0);
    cycle(0, 1);
    chk("t5_err_holds", 32'(err), 32'd1);
    cycle(1, 0); cycle(0, 0);
    chk("t5_err_cleared", 32'(err), 32'd0);

    // 6: reset during a pending fetch, late ack lands in IDLE
    ack_lat = 10;
    cycle(0, 1);
    cycle(0, 0);
    cycle(1, 0);
    chk("t6_req_before_rst", 32'(imem_req), 32'd1);
    force_ack = 1;
    cycle(0, 0);
    force_ack = 0;
    cycle(0, 0);
    chk("t6_ir", 32'(ir), 32'd0);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
